faux_uart: RTL and testbench

FAUX_UART -- requirements
Module: faux_uart

---
 rtl/faux_uart.sv | 119 +++++++++++
 tb/tb_faux_uart.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/faux_uart.sv
//------------------------------------------------------------------------------
// Module      : faux_uart
// Description : Cycle-timed stand-in for a UART with independent TX/RX paths.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module faux_uart #(
    parameter int unsigned TX_CYCLES = 16,
    parameter int unsigned RX_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic [7:0] sim_in_byte,
    output logic [7:0] sim_out_byte,
    output logic       tx_ready,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting,
    output logic       recv_error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Counters are loaded with N-1 so completion lands exactly N edges after accept.
    localparam logic [15:0] C_TX_LOAD = 16'(TX_CYCLES - 1);
    localparam logic [15:0] C_RX_LOAD = 16'(RX_CYCLES - 1);

    state_t      r_tx_state;
    state_t      r_rx_state;
    logic [15:0] r_tx_cnt;
    logic [15:0] r_rx_cnt;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_rx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state      <= ST_IDLE;
            r_tx_cnt        <= 16'd0;
            r_tx_data       <= 8'd0;
            sim_out_byte    <= 8'd0;
            tx_ready        <= 1'b0;
            is_transmitting <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            case (r_tx_state)
                ST_IDLE: begin
                    if (transmit) begin
                        r_tx_data       <= tx_byte;
                        r_tx_cnt        <= C_TX_LOAD;
                        r_tx_state      <= ST_BUSY;
                        is_transmitting <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (r_tx_cnt == 16'd0) begin
                        r_tx_state      <= ST_IDLE;
                        is_transmitting <= 1'b0;
                        sim_out_byte    <= r_tx_data;
                        tx_ready        <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                default: r_tx_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= ST_IDLE;
            r_rx_cnt     <= 16'd0;
            r_rx_data    <= 8'd0;
            rx_byte      <= 8'd0;
            received     <= 1'b0;
            is_receiving <= 1'b0;
            recv_error   <= 1'b0;
        end else begin
            received   <= 1'b0;
            recv_error <= 1'b0;
            case (r_rx_state)
                ST_IDLE: begin
                    if (rx_en) begin
                        r_rx_data    <= sim_in_byte;
                        r_rx_cnt     <= C_RX_LOAD;
                        r_rx_state   <= ST_BUSY;
                        is_receiving <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // A strobe while busy is an overrun: the new byte is dropped.
                    if (rx_en) begin
                        recv_error <= 1'b1;
                    end
                    if (r_rx_cnt == 16'd0) begin
                        r_rx_state   <= ST_IDLE;
                        is_receiving <= 1'b0;
                        rx_byte      <= r_rx_data;
                        received     <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_faux_uart.sv
//------------------------------------------------------------------------------
// Module      : tb_faux_uart
// Description : Randomized and directed bench for faux_uart against a deadline-based model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_faux_uart;

    localparam int N_TX = 16;
    localparam int N_RX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en;
    logic [7:0] sim_in_byte;
    logic       transmit;
    logic [7:0] tx_byte;
    logic [7:0] sim_out_byte;
    logic       tx_ready;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_receiving;
    logic       is_transmitting;
    logic       recv_error;

    logic       transmit1;
    logic [7:0] tx_byte1;
    logic [7:0] sim_out_byte1;
    logic       tx_ready1;
    logic       received1;
    logic [7:0] rx_byte1;
    logic       is_receiving1;
    logic       is_transmitting1;
    logic       recv_error1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    faux_uart #(.TX_CYCLES(N_TX), .RX_CYCLES(N_RX)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_en          (rx_en),
        .sim_in_byte    (sim_in_byte),
        .sim_out_byte   (sim_out_byte),
        .tx_ready       (tx_ready),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .received       (received),
        .rx_byte        (rx_byte),
        .is_receiving   (is_receiving),
        .is_transmitting(is_transmitting),
        .recv_error     (recv_error)
    );

    faux_uart #(.TX_CYCLES(1), .RX_CYCLES(1)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .rx_en          (1'b0),
        .sim_in_byte    (8'h00),
        .sim_out_byte   (sim_out_byte1),
        .tx_ready       (tx_ready1),
        .transmit       (transmit1),
        .tx_byte        (tx_byte1),
        .received       (received1),
        .rx_byte        (rx_byte1),
        .is_receiving   (is_receiving1),
        .is_transmitting(is_transmitting1),
        .recv_error     (recv_error1)
    );

    // Reference model: each byte in flight is described by the edge index at which it completes.
    int         cyc = 0;
    bit         m_tx_act, m_rx_act;
    int         m_tx_end, m_rx_end;
    logic [7:0] m_tx_data, m_rx_data;
    logic [7:0] e_sim_out, e_rx_byte;
    logic       e_tx_ready, e_received, e_is_tx, e_is_rx, e_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        cyc++;
        if (rst) begin
            m_tx_act = 0; m_rx_act = 0;
            e_sim_out = 8'h00; e_rx_byte = 8'h00;
            e_tx_ready = 0; e_received = 0; e_is_tx = 0; e_is_rx = 0; e_err = 0;
        end else begin
            e_tx_ready = 0; e_received = 0; e_err = 0;
            if (m_tx_act) begin
                if (cyc == m_tx_end) begin
                    m_tx_act = 0; e_sim_out = m_tx_data; e_tx_ready = 1;
                end
            end else if (transmit) begin
                m_tx_act = 1; m_tx_end = cyc + N_TX; m_tx_data = tx_byte;
            end
            if (m_rx_act) begin
                if (rx_en) e_err = 1;
                if (cyc == m_rx_end) begin
                    m_rx_act = 0; e_rx_byte = m_rx_data; e_received = 1;
                end
            end else if (rx_en) begin
                m_rx_act = 1; m_rx_end = cyc + N_RX; m_rx_data = sim_in_byte;
            end
            e_is_tx = m_tx_act;
            e_is_rx = m_rx_act;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("sim_out_byte",    32'(sim_out_byte),    32'(e_sim_out));
        chk("tx_ready",        32'(tx_ready),        32'(e_tx_ready));
        chk("is_transmitting", 32'(is_transmitting), 32'(e_is_tx));
        chk("rx_byte",         32'(rx_byte),         32'(e_rx_byte));
        chk("received",        32'(received),        32'(e_received));
        chk("is_receiving",    32'(is_receiving),    32'(e_is_rx));
        chk("recv_error",      32'(recv_error),      32'(e_err));
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            transmit = 0; rx_en = 0; rst = 0;
            cycle();
        end
    endtask

    task automatic send(input logic [7:0] b);
        transmit = 1; tx_byte = b;
        cycle();
        transmit = 0; tx_byte = ~b;
    endtask

    task automatic inject(input logic [7:0] b);
        rx_en = 1; sim_in_byte = b;
        cycle();
        rx_en = 0;
    endtask

    initial begin
        rst = 1; transmit = 0; rx_en = 0; tx_byte = 8'h00; sim_in_byte = 8'h00;
        transmit1 = 0; tx_byte1 = 8'h00;
        cycle();
        cycle();

        // Single-cycle instance: busy for one cycle, pulse on the following edge.
        rst = 0; transmit1 = 1; tx_byte1 = 8'hA5;
        cycle();
        transmit1 = 0; tx_byte1 = 8'h00;
        chk("n1_is_tx_after_accept", 32'(is_transmitting1), 32'd1);
        chk("n1_ready_after_accept", 32'(tx_ready1), 32'd0);
        cycle();
        chk("n1_tx_ready", 32'(tx_ready1), 32'd1);
        chk("n1_sim_out",  32'(sim_out_byte1), 32'hA5);
        chk("n1_is_tx_done", 32'(is_transmitting1), 32'd0);
        cycle();
        chk("n1_ready_pulse_end", 32'(tx_ready1), 32'd0);
        chk("n1_sim_out_hold", 32'(sim_out_byte1), 32'hA5);

        // Basic transmit and receive.
        send(8'hA5);
        quiet(20);
        inject(8'h3C);
        quiet(20);

        // Overrun: second strobe five edges after the first.
        inject(8'h11);
        quiet(4);
        inject(8'h22);
        quiet(25);

        // Transmit ignored while busy, then accepted in the tx_ready cycle.
        send(8'h01);
        quiet(4);
        send(8'h02);
        begin
            int k = 0;
            while (!tx_ready && k < 40) begin
                cycle();
                k++;
            end
            chk("tx_ready_seen", 32'(tx_ready), 32'd1);
        end
        send(8'h03);
        quiet(20);
        chk("b2b_final_byte", 32'(sim_out_byte), 32'h03);

        // Reset mid-flight aborts both paths; requests during reset are ignored.
        transmit = 1; tx_byte = 8'h7E; rx_en = 1; sim_in_byte = 8'h81;
        cycle();
        transmit = 0; rx_en = 0;
        quiet(7);
        rst = 1; transmit = 1; rx_en = 1; tx_byte = 8'hC3; sim_in_byte = 8'h4B;
        cycle();
        quiet(20);
        send(8'h55);
        quiet(20);

        // Randomized traffic with occasional resets; tx_byte jitters every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            transmit    = ($urandom_range(0, 7) == 0);
            rx_en       = ($urandom_range(0, 9) == 0);
            tx_byte     = 8'($urandom);
            sim_in_byte = 8'($urandom);
            cycle();
        end
        quiet(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
